mfsk_dds_mod: RTL and testbench
===============================

# mfsk_dds_mod

Parametrised M-ary continuous-phase FSK modulator and the next generation of the team's 8-bit BFSK transmitter. It accepts parallel data words over a valid/ready handshake and slices each word MSB-first into symbols. Each symbol selects one of 2^BITS_PER_SYM tones from a DDS phase accumulator and sine LUT. Samples are streamed to an external 12-bit SPI DAC (MCP4921-style, 16-bit frames), so the block sits between the packet/data source and the DAC pins.

## Interface
- DATA_W, 8: input word width; must be a multiple of BITS_PER_SYM.
- BITS_PER_SYM, 1: bits per symbol (1 = BFSK, 2 = 4-FSK, 3 = 8-FSK).
- SYM_DIV, 50000: clocks per symbol (1 kHz at 50 MHz).
- SAMPLE_DIV, 250: clocks per DAC sample; must be ≥ 33*SCLK_DIV + 2.
- PHASE_W, 24: phase accumulator width.
- LUT_AW, 8: sine LUT address width (full wave, 2^LUT_AW entries, 12-bit offset binary, mid-scale 0x800).
- FTW_BASE, 838861: tuning word of tone 0.
- FTW_STEP, 838861: tuning-word increment per tone index.
- SCLK_DIV, 4: clocks per SCLK half-period.
- DAC_CFG, 4'b0011: 4 config bits sent ahead of the 12 data bits.
- clk, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high reset.
- data_in, in, DATA_W: word to transmit.
- data_valid, in, 1: data_in valid.
- data_ready, out, 1: block accepts data_in this cycle.
- busy, out, 1: a word is being transmitted.
- sym_strobe, out, 1: one-cycle pulse on the first clock of each symbol.
- cs_dac, out, 1: DAC chip select, active low.
- sclk_dac, out, 1: DAC serial clock (SPI mode 0).
- mosi_dac, out, 1: DAC serial data, MSB first.

## Operation
- Reset values: data_ready=1, busy=0, sym_strobe=0, cs_dac=1, sclk_dac=0, mosi_dac=0. Phase accumulator, all counters and the shift register are cleared. Output tone is idle (mid-scale).
- Symbol FSM, IDLE/RUN:
  - IDLE: data_ready=1. On data_valid&data_ready, load data_in into the shift register, clear the symbol counter, pulse sym_strobe next cycle and go to RUN.
  - RUN: the symbol counter counts 0..SYM_DIV-1. The current tone index is shift_reg[DATA_W-1 -: BITS_PER_SYM]. At wrap, shift left by BITS_PER_SYM, decrement the symbol count and pulse sym_strobe.
- data_ready in RUN is 1 only on the last clock of the last symbol.
  - If data_valid is high then, the new word loads and its first symbol starts on the next clock with no gap. The phase accumulator is not cleared.
  - If data_valid is low then, the FSM returns to IDLE and the phase accumulator clears to 0.
- data_valid while data_ready=0 is ignored; data_in is not sampled.
- FTW = FTW_BASE + tone_idx*FTW_STEP, computed at PHASE_W bits with wrap-around (modulo 2^PHASE_W).
- Sample ticker: free-running 0..SAMPLE_DIV-1, independent of symbol boundaries, and also runs in IDLE.
  - On each tick, LUT address = phase[PHASE_W-1 -: LUT_AW].
  - In RUN: phase ← phase + FTW (modulo 2^PHASE_W, continuous phase across symbols).
  - In IDLE: the sample is forced to 0x800.
- SPI frame: 16 bits = {DAC_CFG, sample[11:0]}, MSB first.
  - Each bit: SCLK_DIV clocks with sclk low, mosi updated at the start of the low phase, then SCLK_DIV clocks with sclk high.
  - After bit 0, sclk returns low and cs_dac returns high for at least SCLK_DIV clocks.
  - A frame in progress is never interrupted by symbol changes.

## Timing
- Tick at cycle T: LUT sample registered at T+1; cs_dac falls at T+2 with mosi = DAC_CFG[3]. First sclk rise at T+2+SCLK_DIV.
- Frame length: 32*SCLK_DIV clocks with cs low (128 at default); cs high at T+2+32*SCLK_DIV.
- Handshake acceptance in IDLE at cycle A: busy=1 and sym_strobe=1 at A+1. The first tone is used at the first tick ≥ A+1.
- Word duration: (DATA_W/BITS_PER_SYM)*SYM_DIV clocks. busy falls on the clock after the last symbol ends unless a back-to-back word is accepted.
- Reset asserted in any state, including mid-SPI-frame: all outputs take their reset values on the next edge, the in-flight word is dropped, and the frame is aborted (cs_dac=1).
- Defaults: 200 kHz sample rate; tones 10 kHz + k*10 kHz; 200 DAC frames per symbol.

## Test plan
- Reset for 3 cycles mid-frame during RUN -> next edge cs_dac=1, sclk_dac=0, mosi_dac=0, data_ready=1, busy=0. Next frame carries 0x3800.
- Idle, no data_valid -> SPI frame every 250 clocks, each exactly 0x3800, 16 sclk rising edges, cs low for 128 clocks.
- BFSK send 0xA5 -> 8 sym_strobe pulses 50000 clocks apart. Per-sample phase increment decodes tones 1,0,1,0,0,1,0,1. 200 frames per symbol. busy low after 400000 clocks.
- Back-to-back 0xA5 then 0x5A, data_valid held -> data_ready high exactly one cycle (last clock of symbol 7). No gap between symbols. Phase not reset at the word boundary (continuity across the boundary).
- BITS_PER_SYM=2 instance, send 0x1B -> 4 symbols with tone indices 0,1,2,3 (10/20/30/40 kHz). busy lasts 200000 clocks.
- data_valid pulsed with 0xFF while busy and data_ready=0 -> word ignored. Only the previously accepted word is transmitted.

Source files
------------

// File: rtl/mfsk_dds_mod_if.sv
// mfsk_dds_mod_if
//   Word handshake between the data source and the MFSK modulator.
//   data_in    : word to transmit (DATA_W bits)
//   data_valid : data_in is valid
//   data_ready : modulator accepts data_in this cycle
//   Modports: master (data source), slave (modulator).
interface mfsk_dds_mod_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_in, output data_valid, input data_ready);
    modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/mfsk_dds_mod.sv
// mfsk_dds_mod
//   M-ary continuous-phase FSK modulator. Words arriving on the handshake
//   are sliced MSB-first into BITS_PER_SYM-bit symbols; each symbol selects
//   a DDS tuning word. A free-running sample ticker reads the sine LUT and
//   ships each 12-bit sample to an MCP4921-style DAC as a 16-bit SPI frame.
// Ports
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : data_in / data_valid / data_ready word handshake
//   o_busy         : a word is being transmitted
//   o_sym_strobe   : one-cycle pulse on the first clock of each symbol
//   o_cs_dac       : DAC chip select, active low
//   o_sclk_dac     : DAC serial clock, SPI mode 0
//   o_mosi_dac     : DAC serial data, MSB first
module mfsk_dds_mod #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned BITS_PER_SYM = 1,
    parameter int unsigned SYM_DIV      = 50000,
    parameter int unsigned SAMPLE_DIV   = 250,
    parameter int unsigned PHASE_W      = 24,
    parameter int unsigned LUT_AW       = 8,
    parameter int unsigned FTW_BASE     = 838861,
    parameter int unsigned FTW_STEP     = 838861,
    parameter int unsigned SCLK_DIV     = 4,
    parameter logic [3:0]  DAC_CFG      = 4'b0011
) (
    input  logic          i_clk,
    input  logic          i_reset,
    mfsk_dds_mod_if.slave bus,
    output logic          o_busy,
    output logic          o_sym_strobe,
    output logic          o_cs_dac,
    output logic          o_sclk_dac,
    output logic          o_mosi_dac
);
    localparam int unsigned NSYM      = DATA_W / BITS_PER_SYM;
    localparam int unsigned SC_W      = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam int unsigned SL_W      = $clog2(NSYM + 1);
    localparam int unsigned TW        = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned DW        = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int          LUT_DEPTH = 2 ** LUT_AW;

    localparam logic [SC_W-1:0] SYM_LAST  = SC_W'(SYM_DIV - 1);
    localparam logic [TW-1:0]   TICK_LAST = TW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0]   DIV_LAST  = DW'(SCLK_DIV - 1);
    localparam logic [11:0]     MID_SCALE = 12'h800;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    // Full-wave offset-binary sine table, evaluated at elaboration.
    function automatic logic [11:0] sine_entry(input int unsigned idx);
        real ang;
        ang = 2.0 * 3.141592653589793 * real'(idx) / real'(LUT_DEPTH);
        return 12'($rtoi(2048.0 + 2047.0 * $sin(ang) + 0.5));
    endfunction

    logic [11:0] w_lut [LUT_DEPTH];
    for (genvar g = 0; g < LUT_DEPTH; g++) begin : g_lut
        assign w_lut[g] = sine_entry(g);
    end

    state_t                  r_state, w_state_next;
    logic [DATA_W-1:0]       r_shift;
    logic [SC_W-1:0]         r_sym_cnt;
    logic [SL_W-1:0]         r_sym_left;
    logic                    r_sym_strobe;
    logic [TW-1:0]           r_tick_cnt;
    logic [PHASE_W-1:0]      r_phase;
    logic [11:0]             r_sample;
    logic                    r_start;
    logic                    r_spi_active, r_spi_half, r_cs, r_sclk, r_mosi;
    logic [DW-1:0]           r_div_cnt;
    logic [3:0]              r_bit_idx;
    logic [15:0]             r_spi_shift;

    logic                    w_sym_wrap, w_last, w_ready, w_accept, w_tick;
    logic [BITS_PER_SYM-1:0] w_tone;
    logic [PHASE_W-1:0]      w_ftw;

    assign w_sym_wrap = (r_state == S_RUN) && (r_sym_cnt == SYM_LAST);
    assign w_last     = w_sym_wrap && (r_sym_left == '0);
    assign w_ready    = (r_state == S_IDLE) || w_last;
    assign w_accept   = bus.data_valid && w_ready;
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_tone     = r_shift[DATA_W-1 -: BITS_PER_SYM];
    assign w_ftw      = PHASE_W'(FTW_BASE) + PHASE_W'(w_tone) * PHASE_W'(FTW_STEP);

    assign bus.data_ready = w_ready;
    assign o_busy         = (r_state == S_RUN);
    assign o_sym_strobe   = r_sym_strobe;
    assign o_cs_dac       = r_cs;
    assign o_sclk_dac     = r_sclk;
    assign o_mosi_dac     = r_mosi;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (w_last && !bus.data_valid) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Symbol slicing. An accept on the last clock of a word reloads in
    // place, so back-to-back words run without a gap.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift      <= '0;
            r_sym_cnt    <= '0;
            r_sym_left   <= '0;
            r_sym_strobe <= 1'b0;
        end else begin
            r_sym_strobe <= w_accept || (w_sym_wrap && !w_last);
            if (w_accept) begin
                r_shift    <= bus.data_in;
                r_sym_cnt  <= '0;
                r_sym_left <= SL_W'(NSYM - 1);
            end else if (r_state == S_RUN) begin
                if (w_sym_wrap) begin
                    r_sym_cnt  <= '0;
                    r_shift    <= r_shift << BITS_PER_SYM;
                    r_sym_left <= r_sym_left - SL_W'(1);
                end else begin
                    r_sym_cnt <= r_sym_cnt + SC_W'(1);
                end
            end
        end
    end

    // Sample ticker and phase accumulator; phase only clears when a word
    // ends without a follow-on, keeping phase continuous across symbols.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
            r_phase    <= '0;
            r_sample   <= MID_SCALE;
            r_start    <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            r_start    <= w_tick;
            if (w_tick)
                r_sample <= (r_state == S_RUN) ? w_lut[r_phase[PHASE_W-1 -: LUT_AW]] : MID_SCALE;
            if ((r_state == S_RUN) && (w_state_next == S_IDLE))
                r_phase <= '0;
            else if (w_tick && (r_state == S_RUN))
                r_phase <= r_phase + w_ftw;
        end
    end

    // SPI frame: per bit SCLK_DIV clocks low (mosi changes on entry), then
    // SCLK_DIV clocks high; after bit 0 both cs and sclk return idle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_spi_active <= 1'b0;
            r_spi_half   <= 1'b0;
            r_cs         <= 1'b1;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_div_cnt    <= '0;
            r_bit_idx    <= '0;
            r_spi_shift  <= '0;
        end else if (r_start) begin
            r_spi_active <= 1'b1;
            r_spi_half   <= 1'b0;
            r_cs         <= 1'b0;
            r_sclk       <= 1'b0;
            r_mosi       <= DAC_CFG[3];
            r_div_cnt    <= '0;
            r_bit_idx    <= 4'd15;
            r_spi_shift  <= {DAC_CFG, r_sample};
        end else if (r_spi_active) begin
            if (r_div_cnt == DIV_LAST) begin
                r_div_cnt <= '0;
                if (!r_spi_half) begin
                    r_spi_half <= 1'b1;
                    r_sclk     <= 1'b1;
                end else if (r_bit_idx == 4'd0) begin
                    r_spi_active <= 1'b0;
                    r_spi_half   <= 1'b0;
                    r_cs         <= 1'b1;
                    r_sclk       <= 1'b0;
                    r_mosi       <= 1'b0;
                end else begin
                    r_spi_half <= 1'b0;
                    r_sclk     <= 1'b0;
                    r_bit_idx  <= r_bit_idx - 4'd1;
                    r_mosi     <= r_spi_shift[r_bit_idx - 4'd1];
                end
            end else begin
                r_div_cnt <= r_div_cnt + DW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mfsk_dds_mod.sv
module tb_mfsk_dds_mod;
    localparam int SYMD  = 700;
    localparam int SAMPD = 70;
    localparam int SCKD  = 2;
    localparam real PI   = 3.141592653589793;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     n_vec = 0;
    int     n_err = 0;

    logic [1:0] busy, strobe, cs, sclk, mosi, ready;

    mfsk_dds_mod_if #(.DATA_W(8)) bus0 ();
    mfsk_dds_mod_if #(.DATA_W(8)) bus1 ();

    mfsk_dds_mod #(.DATA_W(8), .BITS_PER_SYM(1), .SYM_DIV(SYMD), .SAMPLE_DIV(SAMPD), .SCLK_DIV(SCKD)) dut0 (
        .i_clk(clk), .i_reset(rst), .bus(bus0), .o_busy(busy[0]), .o_sym_strobe(strobe[0]),
        .o_cs_dac(cs[0]), .o_sclk_dac(sclk[0]), .o_mosi_dac(mosi[0]));

    mfsk_dds_mod #(.DATA_W(8), .BITS_PER_SYM(2), .SYM_DIV(SYMD), .SAMPLE_DIV(SAMPD), .SCLK_DIV(SCKD)) dut1 (
        .i_clk(clk), .i_reset(rst), .bus(bus1), .o_busy(busy[1]), .o_sym_strobe(strobe[1]),
        .o_cs_dac(cs[1]), .o_sclk_dac(sclk[1]), .o_mosi_dac(mosi[1]));

    assign ready[0] = bus0.data_ready;
    assign ready[1] = bus1.data_ready;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: accepted words with their accept cycle, per instance.
    longint      acc_cyc [2][64];
    int          acc_word[2][64];
    int          n_words [2] = '{0, 0};
    longint      ph      [2] = '{0, 0};
    int          cur_w   [2] = '{-1, -1};
    longint      prev_l  [2] = '{-1, -1};

    // Frame monitor state.
    logic        p_cs    [2] = '{1'b1, 1'b1};
    logic        p_sclk  [2] = '{1'b0, 1'b0};
    logic        in_fr   [2] = '{1'b0, 1'b0};
    logic [15:0] fbits   [2];
    logic [15:0] last_frame [2];
    int          nrise   [2];
    int          frames  [2] = '{0, 0};
    longint      fall_c  [2];
    longint      last_fall [2];
    logic        lf_valid [2] = '{1'b0, 1'b0};

    function automatic int nsym(input int d);
        return 8 / (d + 1);
    endfunction

    function automatic logic [11:0] lut(input longint a);
        return 12'($rtoi(2048.0 + 2047.0 * $sin(2.0 * PI * real'(a) / 256.0) + 0.5));
    endfunction

    // Sample the DAC should carry for a tick at cycle t: a word is on air
    // for cycles A+1 .. A+nsym*SYMD; ticks outside any word give mid-scale
    // and reset the phase, and phase carries over only between abutting words.
    function automatic logic [11:0] exp_sample(input int d, input longint t);
        int          idx;
        longint      wl, k, tone, a;
        logic [11:0] s;
        idx = -1;
        wl  = longint'(nsym(d)) * SYMD;
        for (int i = 0; i < n_words[d]; i++)
            if (t >= acc_cyc[d][i] + 1 && t <= acc_cyc[d][i] + wl) idx = i;
        if (idx < 0) begin
            ph[d] = 0; cur_w[d] = -1; prev_l[d] = -1;
            return 12'h800;
        end
        a = acc_cyc[d][idx];
        if (idx != cur_w[d]) begin
            if (a != prev_l[d]) ph[d] = 0;
            cur_w[d]  = idx;
            prev_l[d] = a + wl;
        end
        k    = (t - a - 1) / SYMD;
        tone = (longint'(acc_word[d][idx]) >> (8 - (d + 1) * (k + 1))) & ((64'd1 << (d + 1)) - 1);
        s    = lut(ph[d] >> 16);
        ph[d] = (ph[d] + 838861 + tone * 838861) % (64'd1 << 24);
        return s;
    endfunction

    task automatic push_word(input int d, input longint a, input int w);
        acc_cyc[d][n_words[d]]  = a;
        acc_word[d][n_words[d]] = w;
        n_words[d]++;
    endtask

    task automatic drive(input int d, input logic v, input logic [7:0] x);
        if (d == 0) begin bus0.data_valid = v; bus0.data_in = x; end
        else        begin bus1.data_valid = v; bus1.data_in = x; end
    endtask

    // SPI frame monitor, sampling on the falling clock edge.
    initial begin
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    in_fr[d] = 1'b0; lf_valid[d] = 1'b0; n_words[d] = 0;
                    ph[d] = 0; cur_w[d] = -1; prev_l[d] = -1;
                    p_cs[d] = 1'b1; p_sclk[d] = 1'b0;
                end else begin
                    if (p_cs[d] && !cs[d]) begin
                        if (lf_valid[d]) begin
                            n_vec++;
                            if ((cyc - last_fall[d]) !== longint'(SAMPD)) begin
                                n_err++;
                                $display("FAIL frame_period dut%0d: got %0d want %0d", d, cyc - last_fall[d], SAMPD);
                            end
                        end
                        n_vec++;
                        if (mosi[d] !== 1'b0) begin
                            n_err++;
                            $display("FAIL first_mosi dut%0d: got %b want 0", d, mosi[d]);
                        end
                        last_fall[d] = cyc; lf_valid[d] = 1'b1;
                        in_fr[d] = 1'b1; fall_c[d] = cyc; nrise[d] = 0; fbits[d] = '0;
                    end
                    if (in_fr[d] && !cs[d] && !p_sclk[d] && sclk[d]) begin
                        fbits[d] = {fbits[d][14:0], mosi[d]};
                        nrise[d]++;
                    end
                    if (in_fr[d] && !p_cs[d] && cs[d]) begin
                        in_fr[d] = 1'b0;
                        frames[d]++;
                        last_frame[d] = fbits[d];
                        n_vec++;
                        if ((cyc - fall_c[d]) !== longint'(32 * SCKD)) begin
                            n_err++;
                            $display("FAIL cs_low_len dut%0d: got %0d want %0d", d, cyc - fall_c[d], 32 * SCKD);
                        end
                        n_vec++;
                        if (nrise[d] !== 16) begin
                            n_err++;
                            $display("FAIL sclk_rises dut%0d: got %0d want 16", d, nrise[d]);
                        end
                        exp = {4'b0011, exp_sample(d, fall_c[d] - 2)};
                        n_vec++;
                        if (fbits[d] !== exp) begin
                            n_err++;
                            $display("FAIL frame_data dut%0d tick %0d: got %h want %h", d, fall_c[d] - 2, fbits[d], exp);
                        end
                        n_vec++;
                        if (sclk[d] !== 1'b0) begin
                            n_err++;
                            $display("FAIL sclk_idle dut%0d: got %b want 0", d, sclk[d]);
                        end
                    end
                    p_cs[d] = cs[d]; p_sclk[d] = sclk[d];
                end
            end
        end
    end

    // Sends w1 (and w2 back-to-back if b2b) from idle and checks strobe,
    // busy and ready cycle by cycle; inj>0 pulses 0xFF at A+inj.
    task automatic run_words(input int d, input int w1, input bit b2b, input int w2, input int inj);
        longint a, wl, total;
        int     bad_str, bad_busy, bad_rdy;
        longint first_bad;
        logic   e_str, e_busy, e_rdy, v;
        logic [7:0] x;
        bad_str = 0; bad_busy = 0; bad_rdy = 0; first_bad = -1;
        wl    = longint'(nsym(d)) * SYMD;
        total = b2b ? 2 * wl : wl;
        @(negedge clk);
        n_vec++;
        if (ready[d] !== 1'b1) begin
            n_err++;
            $display("FAIL idle_ready dut%0d: got %b want 1", d, ready[d]);
        end
        drive(d, 1'b1, 8'(w1));
        a = cyc;
        push_word(d, a, w1);
        for (longint c = a + 1; c <= a + total + 1; c++) begin
            @(negedge clk);
            e_busy = (c <= a + total);
            e_str  = e_busy && (((c - a - 1) % SYMD) == 0);
            e_rdy  = e_busy ? (((c - a) % wl) == 0) : 1'b1;
            if (strobe[d] !== e_str)  begin bad_str++;  if (first_bad < 0) first_bad = c - a; end
            if (busy[d]   !== e_busy) begin bad_busy++; if (first_bad < 0) first_bad = c - a; end
            if (ready[d]  !== e_rdy)  begin bad_rdy++;  if (first_bad < 0) first_bad = c - a; end
            v = 1'b0;
            x = 8'($urandom_range(0, 255));
            if (b2b && c <= a + wl) begin v = 1'b1; x = 8'(w2); end
            if (inj > 0 && c == a + inj) begin v = 1'b1; x = 8'hFF; end
            drive(d, v, x);
            if (b2b && c == a + wl) push_word(d, c, w2);
        end
        drive(d, 1'b0, 8'h00);
        n_vec++;
        if (bad_str !== 0) begin
            n_err++;
            $display("FAIL sym_strobe dut%0d word %h: got %0d bad cycles want 0 (first at A+%0d)", d, w1, bad_str, first_bad);
        end
        n_vec++;
        if (bad_busy !== 0) begin
            n_err++;
            $display("FAIL busy dut%0d word %h: got %0d bad cycles want 0 (first at A+%0d)", d, w1, bad_busy, first_bad);
        end
        n_vec++;
        if (bad_rdy !== 0) begin
            n_err++;
            $display("FAIL data_ready dut%0d word %h: got %0d bad cycles want 0 (first at A+%0d)", d, w1, bad_rdy, first_bad);
        end
    endtask

    task automatic test_reset;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if ({cs[d], sclk[d], mosi[d], ready[d], busy[d], strobe[d]} !== 6'b100100) begin
                n_err++;
                $display("FAIL reset_outputs dut%0d: got cs,sclk,mosi,rdy,busy,strb=%b want 100100", d,
                         {cs[d], sclk[d], mosi[d], ready[d], busy[d], strobe[d]});
            end
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset_midrun;
        int f0, i;
        @(negedge clk);
        drive(0, 1'b1, 8'h3C);
        push_word(0, cyc, 8'h3C);
        @(negedge clk);
        drive(0, 1'b0, 8'h00);
        i = 0;
        while (cs[0] !== 1'b0 && i < 3 * SAMPD) begin @(negedge clk); i++; end
        n_vec++;
        if (cs[0] !== 1'b0) begin
            n_err++;
            $display("FAIL wait_frame dut0: got cs=%b want 0 within %0d cycles", cs[0], 3 * SAMPD);
        end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({cs[0], sclk[0], mosi[0], ready[0], busy[0], strobe[0]} !== 6'b100100) begin
            n_err++;
            $display("FAIL midframe_reset dut0: got cs,sclk,mosi,rdy,busy,strb=%b want 100100",
                     {cs[0], sclk[0], mosi[0], ready[0], busy[0], strobe[0]});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        f0 = frames[0];
        i = 0;
        while (frames[0] == f0 && i < 3 * SAMPD) begin @(negedge clk); i++; end
        n_vec++;
        if (frames[0] == f0 || last_frame[0] !== 16'h3800) begin
            n_err++;
            $display("FAIL post_reset_frame dut0: got %h (frames %0d->%0d) want 3800", last_frame[0], f0, frames[0]);
        end
    endtask

    task automatic test_idle;
        int f0, f1;
        f0 = frames[0]; f1 = frames[1];
        repeat (5 * SAMPD) @(negedge clk);
        n_vec++;
        if (frames[0] - f0 < 4 || frames[1] - f1 < 4) begin
            n_err++;
            $display("FAIL idle_frames: got %0d/%0d frames want >=4 each", frames[0] - f0, frames[1] - f1);
        end
        n_vec++;
        if (last_frame[0] !== 16'h3800) begin
            n_err++;
            $display("FAIL idle_frame_value dut0: got %h want 3800", last_frame[0]);
        end
    endtask

    task automatic test_bfsk;
        run_words(0, 8'hA5, 1'b0, 0, 0);
    endtask

    task automatic test_back_to_back;
        run_words(0, 8'hA5, 1'b1, 8'h5A, 0);
    endtask

    task automatic test_4fsk;
        run_words(1, 8'h1B, 1'b0, 0, 0);
    endtask

    task automatic test_ignore_busy;
        run_words(0, 8'h0F, 1'b0, 0, $urandom_range(50, 8 * SYMD - 50));
        run_words(1, 8'h90, 1'b0, 0, $urandom_range(50, 4 * SYMD - 50));
    endtask

    task automatic test_random;
        for (int n = 0; n < 3; n++) begin
            run_words(n % 2, $urandom_range(0, 255), 1'(n == 1), $urandom_range(0, 255), 0);
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: got no completion want summary before time limit");
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_idle();
        test_reset_midrun();
        test_bfsk();
        test_back_to_back();
        test_4fsk();
        test_ignore_busy();
        test_random();
        repeat (3 * SAMPD) @(negedge clk);
        n_vec++;
        if (frames[0] < 100 || frames[1] < 100) begin
            n_err++;
            $display("FAIL frame_count: got %0d/%0d want >=100 each", frames[0], frames[1]);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
